// File: rtl/sar_pkg.sv
// -----------------------------------------------------------------------------
// sar_pkg
// Shared definitions for the SAR result averager.
//   - state_e      : averager FSM state encoding (IDLE, ACC)
//   - acc_width()  : accumulator width, NBITS + LOG2_AVG
//   - round_const(): round-half-up constant added before the final shift
// -----------------------------------------------------------------------------
package sar_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_e;

    // Sum of 2^LOG2_AVG samples of NBITS each never needs more than this.
    function automatic int acc_width(input int nbits, input int log2_avg);
        return nbits + log2_avg;
    endfunction

    // Half of one output LSB expressed in accumulator units; zero when the
    // averager is a pass-through.
    function automatic int round_const(input int log2_avg);
        return (log2_avg == 0) ? 0 : (1 << (log2_avg - 1));
    endfunction

endpackage : sar_pkg

// File: rtl/sar_result_avg_if.sv
// -----------------------------------------------------------------------------
// sar_result_avg_if
// Bundles the SAR-facing and back-end-facing signals of the result averager.
//   EN, CLR            : control from the system
//   GO                 : conversion request to the SAR
//   VALID_IN, RESULTP,
//   RESULTN            : finished conversion from the SAR
//   DOUT, DOUT_VALID,
//   DOUT_READY         : averaged result, valid/ready toward the back end
//   OVERRUN, ERR       : sticky status flags
// Modports: slave = averager view, master = environment view.
// -----------------------------------------------------------------------------
interface sar_result_avg_if #(
    parameter int NBITS = 8
);
    logic             EN;
    logic             CLR;
    logic             GO;
    logic             VALID_IN;
    logic [NBITS-1:0] RESULTP;
    logic [NBITS-1:0] RESULTN;
    logic [NBITS-1:0] DOUT;
    logic             DOUT_VALID;
    logic             DOUT_READY;
    logic             OVERRUN;
    logic             ERR;

    modport slave (
        input  EN, CLR, VALID_IN, RESULTP, RESULTN, DOUT_READY,
        output GO, DOUT, DOUT_VALID, OVERRUN, ERR
    );

    modport master (
        output EN, CLR, VALID_IN, RESULTP, RESULTN, DOUT_READY,
        input  GO, DOUT, DOUT_VALID, OVERRUN, ERR
    );
endinterface : sar_result_avg_if

// File: rtl/sar_result_check.sv
// -----------------------------------------------------------------------------
// sar_result_check
// Combinational P/N consistency check for one SAR conversion. A conversion is
// consistent when every bit was decided exactly once, i.e. RESULTP ^ RESULTN
// is all ones.
//   valid_in : SAR VALID pulse
//   resultp  : SAR RESULTP word
//   resultn  : SAR RESULTN word
//   accept   : valid and consistent -> accumulate
//   reject   : valid but inconsistent -> drop and flag
// Only present in builds with SAR_RESULT_CHECK_EN defined.
// -----------------------------------------------------------------------------
`ifdef SAR_RESULT_CHECK_EN
module sar_result_check #(
    parameter int NBITS = 8
) (
    input  logic             valid_in,
    input  logic [NBITS-1:0] resultp,
    input  logic [NBITS-1:0] resultn,
    output logic             accept,
    output logic             reject
);
    logic consistent;

    assign consistent = ((resultp ^ resultn) == {NBITS{1'b1}});
    assign accept     = valid_in & consistent;
    assign reject     = valid_in & ~consistent;
endmodule : sar_result_check
`endif

// File: rtl/sar_result_avg.sv
// -----------------------------------------------------------------------------
// sar_result_avg
// Requests SAR conversions, averages 2^LOG2_AVG accepted results with
// round-half-up, and offers each average on a valid/ready port.
// Parameters:
//   NBITS    : conversion width (must match the SAR)
//   LOG2_AVG : log2 of samples per average, 0..6 (0 = pass-through)
// Ports:
//   CLK, RST : clock, asynchronous active-high reset
//   bus      : sar_result_avg_if.slave (EN, CLR, GO, VALID_IN, RESULTP,
//              RESULTN, DOUT, DOUT_VALID, DOUT_READY, OVERRUN, ERR)
// Build option:
//   SAR_RESULT_CHECK_EN : drop conversions whose RESULTP/RESULTN disagree and
//                         raise sticky ERR. Undefined: every VALID_IN sample
//                         is accepted, RESULTN is ignored and ERR stays 0.
// -----------------------------------------------------------------------------
module sar_result_avg
    import sar_pkg::*;
#(
    parameter int NBITS    = 8,
    parameter int LOG2_AVG = 2
) (
    input  logic                CLK,
    input  logic                RST,
    sar_result_avg_if.slave     bus
);
    localparam int ACC_W = acc_width(NBITS, LOG2_AVG);
    localparam int CNT_W = (LOG2_AVG > 0) ? LOG2_AVG : 1;
    localparam logic [ACC_W-1:0] RND      = ACC_W'(round_const(LOG2_AVG));
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_AVG) - 1);

    state_e             state_q, state_d;
    logic               go_q, go_d;
    logic [ACC_W-1:0]   acc_sum_q, acc_sum_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NBITS-1:0]   dout_q, dout_d;
    logic               dout_valid_q, dout_valid_d;
    logic               overrun_q, overrun_d;
    logic               err_q, err_d;

    logic               sample_ok;
    logic               sample_bad;
    logic [ACC_W-1:0]   sum_rnd;

`ifdef SAR_RESULT_CHECK_EN
    sar_result_check #(
        .NBITS (NBITS)
    ) u_check (
        .valid_in (bus.VALID_IN),
        .resultp  (bus.RESULTP),
        .resultn  (bus.RESULTN),
        .accept   (sample_ok),
        .reject   (sample_bad)
    );
`else
    logic unused_resultn;

    assign sample_ok      = bus.VALID_IN;
    assign sample_bad     = 1'b0;
    assign unused_resultn = ^bus.RESULTN;
`endif

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        acc_sum_d    = acc_sum_q;
        cnt_d        = cnt_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        overrun_d    = overrun_q;
        err_d        = err_q;
        // Completed-average numerator including the sample arriving now; it
        // cannot overflow ACC_W, so the shift needs no saturation.
        sum_rnd      = acc_sum_q + ACC_W'(bus.RESULTP) + RND;

        if (bus.CLR) begin
            state_d      = ST_IDLE;
            acc_sum_d    = '0;
            cnt_d        = '0;
            dout_valid_d = 1'b0;
            overrun_d    = 1'b0;
            err_d        = 1'b0;
        end else begin
            if (dout_valid_q && bus.DOUT_READY) begin
                dout_valid_d = 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    // Late VALID_IN from a conversion started before EN fell
                    // lands here and is ignored.
                    if (bus.EN) begin
                        state_d = ST_ACC;
                    end
                end
                ST_ACC: begin
                    if (!bus.EN) begin
                        state_d   = ST_IDLE;
                        acc_sum_d = '0;
                        cnt_d     = '0;
                    end else begin
                        if (sample_bad) begin
                            err_d = 1'b1;
                        end
                        if (sample_ok) begin
                            if (cnt_q == CNT_LAST) begin
                                dout_d       = NBITS'(sum_rnd >> LOG2_AVG);
                                dout_valid_d = 1'b1;
                                // Overwrite only counts as overrun when the
                                // old value is not being consumed this cycle.
                                if (dout_valid_q && !bus.DOUT_READY) begin
                                    overrun_d = 1'b1;
                                end
                                acc_sum_d = '0;
                                cnt_d     = '0;
                            end else begin
                                acc_sum_d = acc_sum_q + ACC_W'(bus.RESULTP);
                                cnt_d     = cnt_q + 1'b1;
                            end
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        go_d = (state_d == ST_ACC);
    end

    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            go_q         <= 1'b0;
            acc_sum_q    <= '0;
            cnt_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            go_q         <= go_d;
            acc_sum_q    <= acc_sum_d;
            cnt_q        <= cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overrun_q    <= overrun_d;
            err_q        <= err_d;
        end
    end

    assign bus.GO         = go_q;
    assign bus.DOUT       = dout_q;
    assign bus.DOUT_VALID = dout_valid_q;
    assign bus.OVERRUN    = overrun_q;
    assign bus.ERR        = err_q;

endmodule : sar_result_avg
